// File: rtl/fetch_line_sched.sv
// Fill scheduler for the two-line instruction fetch buffer.
// Owns the slot tags/valids, finds demand misses, schedules next-line prefetches,
// runs one I$ line request at a time and steers each returned line into its slot.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   FetchAdr/FetchValid current fetch address and its qualifier
//   Invalidate          fence.i: drop all slots and any in-flight fill
//   CacheReady          I$ accepts CacheReq this cycle
//   CacheRespValid      I$ line data valid this cycle
//   CacheReq/CacheReqAdr line request and its line-aligned address
//   SlotWrEn            one-hot slot write strobe, coincident with CacheRespValid
//   SlotHit/SlotValid   per-slot hit and valid
//   Stall               fetch valid but not resident
module fetch_line_sched #(
    parameter int unsigned PA_BITS     = 56,
    parameter int unsigned LINELEN     = 512,
    parameter bit          PREFETCH_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PA_BITS-1:0] FetchAdr,
    input  logic               FetchValid,
    input  logic               Invalidate,
    input  logic               CacheReady,
    input  logic               CacheRespValid,
    output logic               CacheReq,
    output logic [PA_BITS-1:0] CacheReqAdr,
    output logic [1:0]         SlotWrEn,
    output logic [1:0]         SlotHit,
    output logic [1:0]         SlotValid,
    output logic               Stall
);

    localparam int unsigned OFF   = $clog2(LINELEN / 8);
    localparam int unsigned TAG_W = PA_BITS - OFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DREQ,
        S_DWAIT,
        S_PREQ,
        S_PWAIT,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q [2];
    logic [TAG_W-1:0]   tag_d [2];
    logic [1:0]         valid_q, valid_d;
    logic               mru_q, mru_d;
    logic               victim_q, victim_d;
    logic [TAG_W-1:0]   req_tag_q, req_tag_d;
    logic               inv_pend_q, inv_pend_d;

    logic [TAG_W-1:0]   fetch_tag;
    logic [TAG_W-1:0]   next_tag;
    logic [1:0]         match;
    logic [1:0]         slot_hit_c;
    logic               any_hit;
    logic               miss;
    logic               next_resident;
    logic               pf_cond;
    logic               dm_victim;
    logic               fill;
    logic               unused_c;

    // Hit / miss / prefetch decode
    assign fetch_tag     = FetchAdr[PA_BITS-1:OFF];
    assign next_tag      = fetch_tag + TAG_W'(1);
    assign match[0]      = valid_q[0] & (tag_q[0] == fetch_tag);
    assign match[1]      = valid_q[1] & (tag_q[1] == fetch_tag);
    // Slot 0 wins if both slots somehow hold the same line
    assign slot_hit_c[0] = FetchValid & match[0];
    assign slot_hit_c[1] = FetchValid & match[1] & ~match[0];
    assign any_hit       = |slot_hit_c;
    assign miss          = FetchValid & ~any_hit;
    assign next_resident = (valid_q[0] & (tag_q[0] == next_tag)) |
                           (valid_q[1] & (tag_q[1] == next_tag));
    // Second half of a resident line; never wrap past the top of the address space
    assign pf_cond       = PREFETCH_EN & any_hit & FetchAdr[OFF-1] &
                           ~next_resident & ~(&fetch_tag);
    assign dm_victim     = ~valid_q[0] ? 1'b0 : (~valid_q[1] ? 1'b1 : ~mru_q);
    assign unused_c      = ^FetchAdr[OFF-2:0];

    assign SlotHit     = slot_hit_c;
    assign SlotValid   = valid_q;
    assign Stall       = miss;
    assign CacheReq    = (state_q == S_DREQ) | (state_q == S_PREQ);
    assign CacheReqAdr = {req_tag_q, {OFF{1'b0}}};

    // Next-state and fill steering
    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        valid_d    = valid_q;
        mru_d      = any_hit ? slot_hit_c[1] : mru_q;
        victim_d   = victim_q;
        req_tag_d  = req_tag_q;
        inv_pend_d = inv_pend_q;
        SlotWrEn   = 2'b00;
        fill       = 1'b0;

        case (state_q)
            S_IDLE: begin
                inv_pend_d = 1'b0;
                if (!Invalidate) begin
                    if (miss) begin
                        state_d   = S_DREQ;
                        victim_d  = dm_victim;
                        req_tag_d = fetch_tag;
                    end else if (pf_cond) begin
                        state_d   = S_PREQ;
                        victim_d  = ~slot_hit_c[1];
                        req_tag_d = next_tag;
                    end
                end
            end
            S_DREQ, S_PREQ: begin
                // An accepted request cannot be recalled; remember to discard its data
                if (Invalidate) inv_pend_d = 1'b1;
                if (CacheReady) begin
                    inv_pend_d = 1'b0;
                    if (inv_pend_q || Invalidate) state_d = S_DRAIN;
                    else state_d = (state_q == S_DREQ) ? S_DWAIT : S_PWAIT;
                end
            end
            S_DWAIT, S_PWAIT: begin
                if (Invalidate) begin
                    // A response coincident with the invalidate is itself the dropped one
                    state_d = CacheRespValid ? S_IDLE : S_DRAIN;
                end else if (CacheRespValid) begin
                    fill    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (CacheRespValid) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fill) begin
            SlotWrEn[victim_q] = 1'b1;
            tag_d[victim_q]    = req_tag_q;
            valid_d[victim_q]  = 1'b1;
        end
        if (Invalidate) valid_d = 2'b00;
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tag_q[0]   <= '0;
            tag_q[1]   <= '0;
            valid_q    <= 2'b00;
            mru_q      <= 1'b0;
            victim_q   <= 1'b0;
            req_tag_q  <= '0;
            inv_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tag_q[0]   <= tag_d[0];
            tag_q[1]   <= tag_d[1];
            valid_q    <= valid_d;
            mru_q      <= mru_d;
            victim_q   <= victim_d;
            req_tag_q  <= req_tag_d;
            inv_pend_q <= inv_pend_d;
        end
    end

endmodule

// File: tb/tb_fetch_line_sched.sv
// Randomized scoreboard bench for fetch_line_sched: one prefetching and one
// demand-only instance share the fetch stream, each with its own I$ responder.
module tb_fetch_line_sched;

    localparam int unsigned PA  = 56;
    localparam int unsigned OFF = 6;
    localparam int unsigned TW  = PA - OFF;

    logic          clk = 1'b0;
    logic          reset;
    logic [PA-1:0] fadr;
    logic          fvalid;
    logic          inval;
    logic          rdy    [2];
    logic          rvalid [2];
    logic          req    [2];
    logic [PA-1:0] radr   [2];
    logic [1:0]    wren   [2];
    logic [1:0]    hit    [2];
    logic [1:0]    sval   [2];
    logic          stall  [2];

    always #5 clk = ~clk;

    fetch_line_sched #(.PA_BITS(PA), .LINELEN(512), .PREFETCH_EN(1'b1)) dut0 (
        .clk(clk), .reset(reset), .FetchAdr(fadr), .FetchValid(fvalid),
        .Invalidate(inval), .CacheReady(rdy[0]), .CacheRespValid(rvalid[0]),
        .CacheReq(req[0]), .CacheReqAdr(radr[0]), .SlotWrEn(wren[0]),
        .SlotHit(hit[0]), .SlotValid(sval[0]), .Stall(stall[0])
    );

    fetch_line_sched #(.PA_BITS(PA), .LINELEN(512), .PREFETCH_EN(1'b0)) dut1 (
        .clk(clk), .reset(reset), .FetchAdr(fadr), .FetchValid(fvalid),
        .Invalidate(inval), .CacheReady(rdy[1]), .CacheRespValid(rvalid[1]),
        .CacheReq(req[1]), .CacheReqAdr(radr[1]), .SlotWrEn(wren[1]),
        .SlotHit(hit[1]), .SlotValid(sval[1]), .Stall(stall[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    // Reference model: slot contents plus one outstanding line transaction per instance
    logic [TW-1:0] m_tag [2][2];
    bit            m_val [2][2];
    int            m_mru [2];
    bit            t_req [2];
    bit            t_wait[2];
    bit            t_drop[2];
    int            t_vic [2];
    int            t_dly [2];
    logic [TW-1:0] t_tag [2];

    logic [PA-1:0] q_adr0[$];
    logic [PA-1:0] q_adr1[$];
    logic [1:0]    q_wr0[$];
    logic [1:0]    q_wr1[$];

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_hit(input int i);
        logic [TW-1:0] ft;
        ft = fadr[PA-1:OFF];
        exp_hit = 2'b00;
        if (fvalid) begin
            if (m_val[i][0] && m_tag[i][0] == ft) exp_hit = 2'b01;
            else if (m_val[i][1] && m_tag[i][1] == ft) exp_hit = 2'b10;
        end
    endfunction

    function automatic logic [PA-1:0] rand_adr();
        logic [TW-1:0] tg;
        int sel;
        sel = $urandom_range(0, 5);
        if (sel < 4) tg = TW'(64 + sel);
        else if (sel == 4) tg = '1;
        else tg = '1 - TW'(1);
        rand_adr = {tg, 6'($urandom_range(0, 63))};
    endfunction

    // Advance the model across one clock edge, pushing expected responses
    task automatic model_step(input int i);
        logic [1:0]    h;
        logic [TW-1:0] ft;
        logic [TW-1:0] nt;
        bit            busy;
        bit            nres;
        bit            go;
        int            v;
        logic [1:0]    oh;
        h    = exp_hit(i);
        ft   = fadr[PA-1:OFF];
        nt   = ft + TW'(1);
        busy = t_req[i] || t_wait[i];
        go   = 1'b0;
        v    = 0;
        if (h != 2'b00) m_mru[i] = (h == 2'b10) ? 1 : 0;
        if (t_req[i] && rdy[i]) begin
            t_req[i]  = 1'b0;
            t_wait[i] = 1'b1;
            t_dly[i]  = $urandom_range(1, 4);
        end else if (t_wait[i] && rvalid[i]) begin
            oh = 2'b00;
            if (!(t_drop[i] || inval)) begin
                m_tag[i][t_vic[i]] = t_tag[i];
                m_val[i][t_vic[i]] = 1'b1;
                oh = (t_vic[i] == 0) ? 2'b01 : 2'b10;
            end
            if (i == 0) q_wr0.push_back(oh); else q_wr1.push_back(oh);
            t_wait[i] = 1'b0;
            t_drop[i] = 1'b0;
        end
        if (inval && (t_req[i] || t_wait[i])) t_drop[i] = 1'b1;
        if (inval) begin
            m_val[i][0] = 1'b0;
            m_val[i][1] = 1'b0;
        end
        if (!busy && !inval) begin
            nres = (m_val[i][0] && m_tag[i][0] == nt) || (m_val[i][1] && m_tag[i][1] == nt);
            if (fvalid && h == 2'b00) begin
                go = 1'b1;
                t_tag[i] = ft;
                if (!m_val[i][0]) v = 0;
                else if (!m_val[i][1]) v = 1;
                else v = 1 - m_mru[i];
            end else if (i == 0 && h != 2'b00 && fadr[OFF-1] && !nres && ft != '1) begin
                go = 1'b1;
                t_tag[i] = nt;
                v = (h == 2'b01) ? 1 : 0;
            end
            if (go) begin
                t_req[i] = 1'b1;
                t_vic[i] = v;
                if (i == 0) q_adr0.push_back({t_tag[i], 6'd0});
                else q_adr1.push_back({t_tag[i], 6'd0});
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake or a fill
    bit            prev_hold [2];
    logic [PA-1:0] prev_adr  [2];
    initial begin
        logic [PA-1:0] ea;
        logic [1:0]    ew;
        prev_hold[0] = 1'b0;
        prev_hold[1] = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (run) begin
                for (int i = 0; i < 2; i++) begin
                    if (prev_hold[i]) begin
                        chk("req_held", i, 64'(req[i]), 64'd1);
                        chk("adr_stable", i, 64'(radr[i]), 64'(prev_adr[i]));
                    end
                    if (rvalid[i]) begin
                        if ((i == 0 ? q_wr0.size() : q_wr1.size()) == 0) begin
                            chk("wr_queue_empty", i, 64'(wren[i]), 64'hx);
                        end else begin
                            ew = (i == 0) ? q_wr0.pop_front() : q_wr1.pop_front();
                            chk("slot_wren", i, 64'(wren[i]), 64'(ew));
                        end
                    end else begin
                        chk("wren_idle", i, 64'(wren[i]), 64'd0);
                    end
                    if (req[i] && rdy[i]) begin
                        if ((i == 0 ? q_adr0.size() : q_adr1.size()) == 0) begin
                            chk("adr_queue_empty", i, 64'(radr[i]), 64'hx);
                        end else begin
                            ea = (i == 0) ? q_adr0.pop_front() : q_adr1.pop_front();
                            chk("req_adr", i, 64'(radr[i]), 64'(ea));
                        end
                    end
                    prev_hold[i] = req[i] && !rdy[i];
                    prev_adr[i]  = radr[i];
                end
            end
        end
    end

    // Driver: stimulus, I$ responders, per-cycle level checks and model stepping
    initial begin
        bit drain;
        reset  = 1'b0;
        fadr   = '0;
        fvalid = 1'b0;
        inval  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rdy[i] = 1'b0; rvalid[i] = 1'b0;
            t_req[i] = 1'b0; t_wait[i] = 1'b0; t_drop[i] = 1'b0;
            t_vic[i] = 0; t_dly[i] = 0; t_tag[i] = '0; m_mru[i] = 0;
            for (int s = 0; s < 2; s++) begin
                m_val[i][s] = 1'b0;
                m_tag[i][s] = '0;
            end
        end
        #1 reset = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_valid", i, 64'(sval[i]), 64'd0);
            chk("rst_req", i, 64'(req[i]), 64'd0);
            chk("rst_adr", i, 64'(radr[i]), 64'd0);
            chk("rst_wren", i, 64'(wren[i]), 64'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;
        fadr  = {TW'(64), 6'd0};
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            drain  = (cyc >= 3800);
            fvalid = !drain && ($urandom_range(0, 9) < 8);
            if (!drain && $urandom_range(0, 9) < 4) fadr = rand_adr();
            inval = !drain && ($urandom_range(0, 49) == 0);
            for (int i = 0; i < 2; i++) begin
                rdy[i]    = drain || ($urandom_range(0, 9) < 6);
                rvalid[i] = 1'b0;
                if (t_wait[i]) begin
                    t_dly[i]--;
                    if (t_dly[i] == 0) rvalid[i] = 1'b1;
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                chk("slot_hit", i, 64'(hit[i]), 64'(exp_hit(i)));
                chk("stall", i, 64'(stall[i]), 64'(fvalid && exp_hit(i) == 2'b00));
                chk("slot_valid", i, 64'(sval[i]), 64'({m_val[i][1], m_val[i][0]}));
                chk("cache_req", i, 64'(req[i]), 64'(t_req[i]));
                model_step(i);
            end
        end
        @(negedge clk);
        #3;
        chk("adr_left", 0, 64'(q_adr0.size()), 64'd0);
        chk("adr_left", 1, 64'(q_adr1.size()), 64'd0);
        chk("wr_left", 0, 64'(q_wr0.size()), 64'd0);
        chk("wr_left", 1, 64'(q_wr1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
